// File: rtl/decode_queue_ctrl.sv
// decode_queue_ctrl
//   Decode-stage instruction queue between fetch and the two decoder slots.
//   Buffers fetched instruction pairs in a circular queue. It presents the
//   oldest one or two entries to decoder slots 0/1 in program order. It applies
//   back-pressure to fetch, and a flush discards all queued entries.
//
// Ports
//   clk            clock, all state on rising edge
//   rst_n          synchronous active-low reset
//   flush_i        discard all entries (beats any same-cycle enqueue/dequeue)
//   fetch_valid_i  fetch bundle present
//   fetch_mask_i   per-slot valid in bundle, bit 0 = older slot
//   fetch_instr_i  bundle instructions, slot0 = [31:0]
//   fetch_pc_i     bundle PCs, slot0 = [31:0]
//   fetch_ready_o  queue has room for a full 2-wide bundle
//   dec_valid_o    decoder slot k holds a valid instruction
//   dec_instr_o    instructions to decoders, slot0 = [31:0]
//   dec_pc_o       PCs matching dec_instr_o
//   dec_ready_i    per-slot consume request (thermometer, in order)
//   count_o        occupied entries, 0..DEPTH
module decode_queue_ctrl #(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             fetch_valid_i,
    input  logic [1:0]       fetch_mask_i,
    input  logic [63:0]      fetch_instr_i,
    input  logic [63:0]      fetch_pc_i,
    output logic             fetch_ready_o,
    output logic [1:0]       dec_valid_o,
    output logic [63:0]      dec_instr_o,
    output logic [63:0]      dec_pc_o,
    input  logic [1:0]       dec_ready_i,
    output logic [PTR_W:0]   count_o
);

    localparam int unsigned CW = PTR_W + 1;

    // Each entry is {instr[31:0], pc[31:0]}.
    logic [63:0]      mem [DEPTH];

    // Pointers carry a wrap bit in the MSB.
    logic [PTR_W:0]   head;
    logic [PTR_W:0]   tail;
    logic [PTR_W:0]   count;

    logic [1:0]       valid;
    logic             ready;
    logic             enq_fire;
    logic [PTR_W:0]   enq_n;
    logic [PTR_W:0]   deq_n;

    logic [PTR_W-1:0] head_idx;
    logic [PTR_W-1:0] head_nxt_idx;
    logic [PTR_W-1:0] tail_idx;
    logic [PTR_W-1:0] tail_nxt_idx;

    always_comb begin
        // Flags come only from the registered count, so there is no
        // combinational path from dec_ready_i to fetch_ready_o.
        valid    = {count >= CW'(2), count >= CW'(1)};
        ready    = count <= CW'(DEPTH - 2);
        enq_fire = fetch_valid_i & ready & ~flush_i;

        enq_n = '0;
        if (enq_fire) begin
            enq_n = CW'(fetch_mask_i[0]) + CW'(fetch_mask_i[1]);
        end

        // Slot1 can only be consumed together with slot0; ready on an
        // invalid slot consumes nothing.
        deq_n = '0;
        if (dec_ready_i[0] && valid[0]) begin
            deq_n = (dec_ready_i[1] && valid[1]) ? CW'(2) : CW'(1);
        end

        head_idx     = head[PTR_W-1:0];
        head_nxt_idx = head_idx + PTR_W'(1);
        tail_idx     = tail[PTR_W-1:0];
        tail_nxt_idx = tail_idx + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + deq_n;
            tail  <= tail + enq_n;
            count <= count + enq_n - deq_n;
        end
    end

    // Valid slots are compacted: a lone slot1 instruction lands at tail.
    always_ff @(posedge clk) begin
        if (rst_n && enq_fire) begin
            case (fetch_mask_i)
                2'b01: mem[tail_idx] <= {fetch_instr_i[31:0], fetch_pc_i[31:0]};
                2'b10: mem[tail_idx] <= {fetch_instr_i[63:32], fetch_pc_i[63:32]};
                2'b11: begin
                    mem[tail_idx]     <= {fetch_instr_i[31:0], fetch_pc_i[31:0]};
                    mem[tail_nxt_idx] <= {fetch_instr_i[63:32], fetch_pc_i[63:32]};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fetch_ready_o = ready;
        dec_valid_o   = valid;
        count_o       = count;
        dec_instr_o   = {mem[head_nxt_idx][63:32], mem[head_idx][63:32]};
        dec_pc_o      = {mem[head_nxt_idx][31:0], mem[head_idx][31:0]};
    end

endmodule

// File: tb/tb_decode_queue_ctrl.sv
// tb_decode_queue_ctrl
//   Self-checking bench for decode_queue_ctrl. A scoreboard queue holds the
//   expected {instr, pc} entries in program order; entries are pushed when a
//   bundle is driven and accepted, and popped when the decoder side consumes.
module tb_decode_queue_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush_i;
    logic             fetch_valid_i;
    logic [1:0]       fetch_mask_i;
    logic [63:0]      fetch_instr_i;
    logic [63:0]      fetch_pc_i;
    logic             fetch_ready_o;
    logic [1:0]       dec_valid_o;
    logic [63:0]      dec_instr_o;
    logic [63:0]      dec_pc_o;
    logic [1:0]       dec_ready_i;
    logic [PTR_W:0]   count_o;

    always #5 clk = ~clk;

    decode_queue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_mask_i  (fetch_mask_i),
        .fetch_instr_i (fetch_instr_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_ready_o (fetch_ready_o),
        .dec_valid_o   (dec_valid_o),
        .dec_instr_o   (dec_instr_o),
        .dec_pc_o      (dec_pc_o),
        .dec_ready_i   (dec_ready_i),
        .count_o       (count_o)
    );

    logic [63:0] sb [$];   // {instr, pc}, oldest first
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = sb.size();
        check("count", 64'(count_o), 64'(n));
        check("dec_valid", 64'(dec_valid_o), {62'b0, n >= 2, n >= 1});
        check("fetch_ready", 64'(fetch_ready_o), 64'((DEPTH - n) >= 2));
        if (n >= 1) begin
            check("s0_instr", 64'(dec_instr_o[31:0]), 64'(sb[0][63:32]));
            check("s0_pc", 64'(dec_pc_o[31:0]), 64'(sb[0][31:0]));
        end
        if (n >= 2) begin
            check("s1_instr", 64'(dec_instr_o[63:32]), 64'(sb[1][63:32]));
            check("s1_pc", 64'(dec_pc_o[63:32]), 64'(sb[1][31:0]));
        end
    endtask

    // Drive one cycle, check outputs, update the scoreboard, advance a clock.
    task automatic step(input logic fl, input logic fv, input logic [1:0] mask,
                        input logic [63:0] instr, input logic [63:0] pc,
                        input logic [1:0] rdy);
        int n;
        int d;
        bit acc;
        flush_i       = fl;
        fetch_valid_i = fv;
        fetch_mask_i  = mask;
        fetch_instr_i = instr;
        fetch_pc_i    = pc;
        dec_ready_i   = rdy;
        #1;
        if (rst_n) check_outputs();
        if (!rst_n || fl) begin
            sb.delete();
        end else begin
            n   = sb.size();
            acc = fv && ((DEPTH - n) >= 2);
            d   = (rdy[0] && n >= 1) ? ((rdy[1] && n >= 2) ? 2 : 1) : 0;
            repeat (d) void'(sb.pop_front());
            if (acc) begin
                if (mask[0]) sb.push_back({instr[31:0], pc[31:0]});
                if (mask[1]) sb.push_back({instr[63:32], pc[63:32]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] rdy);
        step(1'b0, 1'b0, 2'b00, '0, '0, rdy);
    endtask

    task automatic rand_step();
        step(1'b0, 1'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom));
    endtask

    task automatic pair(input logic [31:0] pc0, input logic [1:0] rdy);
        step(1'b0, 1'b1, 2'b11, {pc0 ^ 32'h5A5A_0004, pc0 ^ 32'h5A5A_0000},
             {pc0 + 32'd4, pc0}, rdy);
    endtask

    initial begin
        logic [31:0] pc;
        rst_n = 1'b0;
        flush_i = 1'b0; fetch_valid_i = 1'b0; fetch_mask_i = '0;
        fetch_instr_i = '0; fetch_pc_i = '0; dec_ready_i = '0;

        // Reset held two edges with random inputs.
        rand_step();
        rand_step();
        rst_n = 1'b1;

        // Pair pass-through.
        step(1'b0, 1'b1, 2'b11, {32'h0000_2222, 32'h0000_1111},
             {32'h1C00_0004, 32'h1C00_0000}, 2'b00);
        check("pair_a_const", 64'(dec_instr_o[31:0]), 64'h1111);
        step(1'b0, 1'b0, 2'b00, '0, '0, 2'b11);
        idle(2'b00);

        // Compaction and partial consume.
        step(1'b0, 1'b1, 2'b10, {32'h0000_CCCC, 32'hDEAD_BEEF},
             {32'h1C00_0010, 32'hFFFF_FFFF}, 2'b00);
        idle(2'b10);
        idle(2'b01);
        idle(2'b00);

        // Fill to full; further fetch ignored; consume two.
        pc = 32'h2000_0000;
        for (int i = 0; i < 4; i++) begin
            pair(pc, 2'b00);
            pc += 32'd8;
        end
        pair(32'h3000_0000, 2'b00);
        pair(32'h3000_0008, 2'b00);
        idle(2'b11);
        idle(2'b00);
        while (sb.size() != 0) idle(2'b11);
        idle(2'b00);

        // Wrap-around: 2-in/2-out with sequential PCs.
        pc = 32'h1C00_0000;
        for (int i = 0; i < 2; i++) begin
            pair(pc, 2'b00);
            pc += 32'd8;
        end
        for (int i = 0; i < 20; i++) begin
            pair(pc, 2'b11);
            pc += 32'd8;
        end
        while (sb.size() != 0) idle(2'b11);

        // Flush collides with enqueue and dequeue at count 5.
        pair(32'h4000_0000, 2'b00);
        pair(32'h4000_0008, 2'b00);
        step(1'b0, 1'b1, 2'b01, {32'h0, 32'h4444_0010}, {32'h0, 32'h4000_0010}, 2'b00);
        check("count_five", 64'(count_o), 64'd5);
        step(1'b1, 1'b1, 2'b11, {32'hBAD0_0002, 32'hBAD0_0001},
             {32'h4000_001C, 32'h4000_0018}, 2'b11);
        idle(2'b11);
        idle(2'b11);

        // Random traffic with occasional flush.
        for (int i = 0; i < 120; i++) begin
            step(1'($urandom_range(0, 15) == 0), 1'($urandom), 2'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom));
        end

        // Reset mid-operation overrides everything.
        pair(32'h5000_0000, 2'b00);
        rst_n = 1'b0;
        step(1'b0, 1'b1, 2'b11, {$urandom, $urandom}, {$urandom, $urandom}, 2'b11);
        rst_n = 1'b1;
        idle(2'b00);
        idle(2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_queue_ctrl.md
# decode_queue_ctrl

Decode-stage controller between the fetch stage and the two `Decoder` instances of the dual-issue front end. It buffers fetched instruction pairs in a circular instruction queue and presents up to two oldest instructions per cycle to decoder slot 0 and slot 1 in program order. It handles back-pressure in both directions and discards all queued state on a pipeline flush.

## Interface
- `DEPTH`, 8: queue entries; must be a power of two, ≥ 4.
- `PTR_W`, `$clog2(DEPTH)`: index width (derived, not overridable).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush_i`  in  1  discard all entries; highest priority.
- `fetch_valid_i`  in  1  fetch bundle present.
- `fetch_mask_i`  in  2  per-slot valid within bundle; bit 0 = older slot.
- `fetch_instr_i`  in  64  slot0 = [31:0], slot1 = [63:32].
- `fetch_pc_i`  in  64  slot0 = [31:0], slot1 = [63:32].
- `fetch_ready_o`  out  1  queue can accept a full 2-wide bundle.
- `dec_valid_o`  out  2  decoder slot k holds a valid instruction.
- `dec_instr_o`  out  64  to decoder slots; slot0 = [31:0].
- `dec_pc_o`  out  64  PCs matching `dec_instr_o`.
- `dec_ready_i`  in  2  per-slot consume request from the issue stage.
- `count_o`  out  PTR_W+1  occupied entries, 0..DEPTH.

## Operation
- Storage: DEPTH × {instr[31:0], pc[31:0]} register array. `head` and `tail` pointers are PTR_W+1 bits, with the MSB as the wrap bit.
  - Empty when `head == tail`.
  - Full when the indices are equal and the wrap bits differ.
- Enqueue: `enq_fire = fetch_valid_i & fetch_ready_o & ~flush_i`.
  - Enqueued count is the popcount of `fetch_mask_i` (0, 1, or 2).
  - Valid slots are compacted: mask 2'b10 writes slot1 data at `tail`.
  - Mask 2'b11 writes slot0 at `tail` and slot1 at `tail+1`.
  - Mask 2'b00 is a no-op.
- `fetch_ready_o = (DEPTH - count) >= 2`, computed from registered count only. There is no combinational path from `dec_ready_i`.
- Dequeue presentation is combinational from registered storage:
  - `dec_valid_o[0] = count >= 1`; `dec_valid_o[1] = count >= 2`.
  - Slot0 presents the entry at `head`; slot1 presents the entry at `head+1` (index wraps modulo DEPTH).
  - Unused slot data is don't-care; the bench checks it only when valid.
- Consume count (in-order, thermometer rule):
  - `dec_ready_i` = 2'b01 consumes 1.
  - `dec_ready_i` = 2'b11 consumes 2.
  - 2'b10 and 2'b00 consume 0.
  - Consumption is limited by `dec_valid_o`: a ready on an invalid slot consumes nothing.
- Update each cycle: `head += deq_n`, `tail += enq_n`, `count += enq_n - deq_n`. Simultaneous enqueue and dequeue are both applied.
- Flush: when `flush_i` = 1, the next state is `head = tail = 0` and `count = 0`. The same-cycle enqueue and dequeue are ignored. Storage contents are not cleared.
- State machine: implicit EMPTY / PARTIAL / FULL from `count`; no other FSM.
- Full boundary: at count ≥ DEPTH-1, `fetch_ready_o` = 0, even if the same cycle dequeues.
- Empty boundary: a bundle enqueued into an empty queue is not bypassed; it appears on the decoder side one cycle later.

## Timing
- Reset (`rst_n` = 0 at a rising edge):
  - `head = tail = 0`, `count_o` = 0, `dec_valid_o` = 2'b00, `fetch_ready_o` = 1.
  - `dec_instr_o` and `dec_pc_o` are don't-care while invalid.
- Reset mid-operation is identical to flush plus reset. It overrides `flush_i` and all handshakes.
- Latency: an instruction accepted at edge t is visible on `dec_*` in cycle t+1. A consume at edge t removes it and advances the outputs in cycle t+1.
- Throughput: 2 instructions per cycle sustained in and out, with no bubbles when `count` is 2..DEPTH-2.
- Flush at edge t: `dec_valid_o` = 2'b00 and `fetch_ready_o` = 1 in cycle t+1.
- `fetch_ready_o` and `dec_valid_o` depend only on registers (Moore outputs).

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with random inputs, then release → `count_o`=0, `dec_valid_o`=2'b00, `fetch_ready_o`=1.
- **Pair pass-through:** enqueue mask 2'b11 with instr {B=0x0000_2222, A=0x0000_1111}, PCs {0x1C000004, 0x1C000000}.
  - Next cycle: `dec_valid_o`=2'b11, `dec_instr_o`[31:0]=A, `dec_pc_o`[31:0]=0x1C000000.
  - Apply `dec_ready_i`=2'b11 → `count_o`=0 the cycle after.
- **Compaction and partial consume:** enqueue mask 2'b10 with C → `dec_valid_o`=2'b01 and slot0=C.
  - Apply `dec_ready_i`=2'b10 → nothing consumed; `count_o` stays 1.
  - Apply 2'b01 → `count_o`=0.
- **Full:** with DEPTH=8 and no consume, enqueue three pairs → `count_o`=6 and `fetch_ready_o`=1.
  - Enqueue a 4th pair → `count_o`=8 and `fetch_ready_o`=0.
  - Further `fetch_valid_i` is ignored; `count_o` stays 8.
  - Consume 2 → `count_o`=6 and `fetch_ready_o`=1.
- **Wrap-around:** run 20 cycles of continuous 2-in/2-out with sequential PCs starting at 0x1C000000 → slot order is preserved across pointer wrap and `count_o` stays constant.
- **Flush collision:** at `count_o`=5, assert `flush_i` together with an enqueue (mask 2'b11) and `dec_ready_i`=2'b11 → next cycle `count_o`=0, `dec_valid_o`=2'b00, `fetch_ready_o`=1, and the flushed bundle never appears.
